slave_input_stage: RTL

AXI4-Stream slave front end of the hyperspectral detection pipeline. Accepts band samples from the DMA stream, buffers them in a small FIFO, and presents them to the first processing stage as a DATA_OUT/DATA_OUT_VALID pair that holds under STOP_PIPELINE. It is the upstream mirror of the master output stage, and the same STOP_PIPELINE net can drive both. It also tags each sample with its band index and with pixel/frame boundaries.

---
 rtl/slave_input_stage.sv | 109 ++++++++++
 1 files changed

// File: rtl/slave_input_stage.sv
// slave_input_stage: AXI4-Stream slave FIFO front end with band/pixel/frame tagging.
// Optional macro TLAST_CHECK_EN builds the sticky TLAST_ERROR detector; otherwise TLAST_ERROR is 0.
`timescale 1ns/1ps
`default_nettype none

module slave_input_stage #(
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 4,
  parameter int BANDS      = 16
) (
  input  logic                      CLK,
  input  logic                      RESET,
  input  logic                      S_AXIS_TVALID,
  input  logic [DATA_WIDTH-1:0]     S_AXIS_TDATA,
  input  logic                      S_AXIS_TLAST,
  output logic                      S_AXIS_TREADY,
  input  logic                      STOP_PIPELINE,
  output logic [DATA_WIDTH-1:0]     DATA_OUT,
  output logic                      DATA_OUT_VALID,
  output logic [$clog2(BANDS)-1:0]  BAND_INDEX,
  output logic                      PIXEL_LAST,
  output logic                      FRAME_LAST,
  output logic                      TLAST_ERROR
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int BW = $clog2(BANDS);
  localparam logic [CW-1:0] FULL_COUNT = CW'(FIFO_DEPTH);
  localparam logic [BW-1:0] LAST_BAND  = BW'(BANDS - 1);

  logic [DATA_WIDTH:0]   mem [FIFO_DEPTH];
  logic [PW-1:0]         rd_ptr;
  logic [PW-1:0]         wr_ptr;
  logic [CW-1:0]         count;
  logic [BW-1:0]         band_next;
  logic                  push;
  logic                  pop;
  logic                  head_last;
  logic [DATA_WIDTH-1:0] head_data;

  // Ready depends only on the registered count, never on STOP_PIPELINE.
  always_comb begin
    S_AXIS_TREADY          = (count != FULL_COUNT);
    push                   = S_AXIS_TVALID && S_AXIS_TREADY;
    pop                    = !STOP_PIPELINE && (count != '0);
    {head_last, head_data} = mem[rd_ptr];
  end

  always_ff @(posedge CLK) begin
    if (push) begin
      mem[wr_ptr] <= {S_AXIS_TLAST, S_AXIS_TDATA};
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // band_next is the band the next popped beat will carry.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      DATA_OUT       <= '0;
      DATA_OUT_VALID <= 1'b0;
      BAND_INDEX     <= '0;
      FRAME_LAST     <= 1'b0;
      band_next      <= '0;
    end else if (!STOP_PIPELINE) begin
      if (pop) begin
        DATA_OUT       <= head_data;
        FRAME_LAST     <= head_last;
        DATA_OUT_VALID <= 1'b1;
        BAND_INDEX     <= band_next;
        band_next      <= (head_last || band_next == LAST_BAND) ? '0 : band_next + BW'(1);
      end else begin
        DATA_OUT_VALID <= 1'b0;
      end
    end
  end

  assign PIXEL_LAST = (BAND_INDEX == LAST_BAND);

`ifdef TLAST_CHECK_EN
  always_ff @(posedge CLK) begin
    if (RESET) begin
      TLAST_ERROR <= 1'b0;
    end else if (pop && head_last && band_next != LAST_BAND) begin
      TLAST_ERROR <= 1'b1;
    end
  end
`else
  assign TLAST_ERROR = 1'b0;
`endif

endmodule

`default_nettype wire
